// File: rtl/latency_decoding_pkg.sv
// Shared constants, state encoding and decode helper for the latency decoder.
package latency_decoding_pkg;

  localparam int unsigned N_CH      = 8;
  localparam int unsigned T_STEPS   = 16;
  localparam int unsigned TW        = 4;
  localparam int unsigned DATA_W    = 14;
  localparam int unsigned SCALE_Q   = 279603;
  localparam int unsigned SCALE_W   = 20;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned XMAX      = (1 << DATA_W) - 1;
  localparam int unsigned CH_W      = $clog2(N_CH);
  localparam int unsigned PROD_W    = 24;

  typedef enum logic [1:0] {IDLE, WINDOW, EMIT, DONE} state_t;

  typedef logic [TW-1:0] tstep_t;

  // Drop the Q.8 fraction (truncating) and clamp to the output range.
  function automatic logic [DATA_W-1:0] sat_decode(input logic [PROD_W-1:0] prod);
    logic [PROD_W-1:0] shifted;
    shifted = prod >> FRAC_BITS;
    if (shifted > PROD_W'(XMAX)) sat_decode = DATA_W'(XMAX);
    else                         sat_decode = DATA_W'(shifted);
  endfunction

endpackage

// File: rtl/latency_decoding_mul_4ns_20ns_24_1_1.sv
// Combinational unsigned 4x20 -> 24 bit multiplier; the caller registers dout.
module latency_decoding_mul_4ns_20ns_24_1_1
  import latency_decoding_pkg::*;
(
  input  logic [TW-1:0]      din0,
  input  logic [SCALE_W-1:0] din1,
  output logic [PROD_W-1:0]  dout
);

  assign dout = PROD_W'(din0) * PROD_W'(din1);

endmodule

// File: rtl/latency_decoding.sv
// Time-to-first-spike decoder: captures the first spike step of each channel
// over one window, then streams per-channel decoded magnitudes.
// Optional macro LATENCY_DECODING_EARLY_EXIT_EN ends the window as soon as
// every channel has fired.
module latency_decoding
  import latency_decoding_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic              step_valid,
  output logic              step_ready,
  input  logic [N_CH-1:0]   spike_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_nospike,
  output logic              out_last
);

  state_t            state;
  tstep_t            step_cnt;
  logic [N_CH-1:0]   fired;
  tstep_t            tfirst [N_CH];
  logic [CH_W-1:0]   ch_idx;

  logic              step_acc_c;
  logic              out_hs_c;
  logic [CH_W-1:0]   ch_sel_c;
  tstep_t            mul_a_c;
  logic [PROD_W-1:0] mul_p_c;
  logic [N_CH-1:0]   fired_nxt_c;
  logic              window_end_c;

  // Handshakes, channel being loaded into the output register, window end.
  always_comb begin
    step_acc_c   = step_valid & step_ready;
    out_hs_c     = out_valid & out_ready;
    ch_sel_c     = out_hs_c ? ch_idx + CH_W'(1) : ch_idx;
    mul_a_c      = TW'(T_STEPS - 1) - tfirst[ch_sel_c];
    fired_nxt_c  = fired | spike_in;
    window_end_c = (step_cnt == TW'(T_STEPS - 1));
`ifdef LATENCY_DECODING_EARLY_EXIT_EN
    window_end_c = window_end_c | (&fired_nxt_c);
`endif
  end

  latency_decoding_mul_4ns_20ns_24_1_1 u_mul (
    .din0 (mul_a_c),
    .din1 (SCALE_W'(SCALE_Q)),
    .dout (mul_p_c)
  );

  // Control FSM with capture registers and registered outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      step_cnt    <= '0;
      fired       <= '0;
      ch_idx      <= '0;
      for (int unsigned c = 0; c < N_CH; c++) tfirst[c] <= '0;
      ap_idle     <= 1'b1;
      ap_done     <= 1'b0;
      step_ready  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_nospike <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state      <= WINDOW;
            ap_idle    <= 1'b0;
            step_ready <= 1'b1;
            step_cnt   <= '0;
            fired      <= '0;
            for (int unsigned c = 0; c < N_CH; c++) tfirst[c] <= '0;
          end
        end

        WINDOW: begin
          if (step_acc_c) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
              if (spike_in[c] && !fired[c]) tfirst[c] <= step_cnt;
            end
            fired <= fired_nxt_c;
            if (window_end_c) begin
              state      <= EMIT;
              step_ready <= 1'b0;
              ch_idx     <= '0;
            end else begin
              step_cnt <= step_cnt + TW'(1);
            end
          end
        end

        EMIT: begin
          if (out_hs_c && out_last) begin
            state     <= DONE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ap_done   <= 1'b1;
          end else if (!out_valid || out_hs_c) begin
            ch_idx      <= ch_sel_c;
            out_valid   <= 1'b1;
            out_ch      <= ch_sel_c;
            out_last    <= (ch_sel_c == CH_W'(N_CH - 1));
            out_nospike <= !fired[ch_sel_c];
            out_data    <= fired[ch_sel_c] ? sat_decode(mul_p_c) : '0;
          end
        end

        DONE: begin
          state   <= IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latency_decoding.sv
// Bench for latency_decoding: directed vector table, multi-cycle corner
// sequences and randomized windows against a first-spike reference model.
module tb_latency_decoding;
  import latency_decoding_pkg::*;

  typedef logic [N_CH-1:0] spk_t;

  typedef struct {
    spk_t steps     [T_STEPS];
    int   exp_data  [N_CH];
    bit   exp_ns    [N_CH];
  } vec_t;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic              ap_start;
  logic              ap_idle;
  logic              ap_done;
  logic              step_valid;
  logic              step_ready;
  logic [N_CH-1:0]   spike_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_nospike;
  logic              out_last;

  int total  = 0;
  int passed = 0;

  int got_data [N_CH];
  int got_ch   [N_CH];
  bit got_ns   [N_CH];
  bit got_last [N_CH];
  int nout, first_valid, last_hs_cyc, done_cyc, stall_cycles;

  vec_t tbl [3];

  latency_decoding dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .spike_in    (spike_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_nospike (out_nospike),
    .out_last    (out_last)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: first step index per channel, value = floor((T-1-t)*Q / 2^F), clamped.
  function automatic void model(input spk_t steps [T_STEPS], output int ed [N_CH], output bit en [N_CH]);
    longint v;
    int t;
    for (int ch = 0; ch < N_CH; ch++) begin
      t = -1;
      for (int s = 0; s < T_STEPS; s++) begin
        if (t < 0 && steps[s][ch]) t = s;
      end
      if (t < 0) begin
        ed[ch] = 0;
        en[ch] = 1'b1;
      end else begin
        v = (longint'(T_STEPS - 1 - t) * longint'(SCALE_Q)) / (longint'(1) << FRAC_BITS);
        if (v > longint'(XMAX)) v = longint'(XMAX);
        ed[ch] = int'(v);
        en[ch] = 1'b0;
      end
    end
  endfunction

  // gap: 0 continuous, 1 toggle, 2 random; rdy: 0 always, 1 random, 2 stall ch1 for 5 cycles
  task automatic run_window(input spk_t steps [T_STEPS], input int gap, input int rdy);
    int si;
    bit done, held, acc;
    logic [DATA_W-1:0] h_data;
    logic [CH_W-1:0]   h_ch;
    si = 0; done = 0; held = 0; h_data = '0; h_ch = '0;
    nout = 0; first_valid = -1; last_hs_cyc = -1; done_cyc = -1; stall_cycles = 0;
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (held) begin
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_data", longint'(out_data), longint'(h_data));
        chk("stall_ch", longint'(out_ch), longint'(h_ch));
        held = 0;
      end
      if (si < T_STEPS) begin
        case (gap)
          0:       step_valid = 1'b1;
          1:       step_valid = (cyc % 2 == 0);
          default: step_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        step_valid = 1'b0;
      end
      spike_in = step_valid ? steps[si] : '0;
      case (rdy)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(out_valid && out_ch == CH_W'(1) && stall_cycles < 5);
      endcase
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (ap_done) begin done = 1; done_cyc = cyc; end
      acc = step_valid && step_ready;
      if (out_valid && out_ready) begin
        if (nout < N_CH) begin
          got_data[nout] = int'(out_data);
          got_ch[nout]   = int'(out_ch);
          got_ns[nout]   = out_nospike;
          got_last[nout] = out_last;
        end
        nout++;
        last_hs_cyc = cyc;
      end
      if (out_valid && !out_ready) begin
        held = 1; h_data = out_data; h_ch = out_ch;
        if (rdy == 2) stall_cycles++;
      end
      @(negedge ap_clk);
      if (acc) si++;
    end
    step_valid = 1'b0; spike_in = '0; out_ready = 1'b0;
    chk("done_seen", longint'(done), 1);
    chk("done_after_last", longint'(done_cyc), longint'(last_hs_cyc + 1));
    chk("done_pulse_width", longint'(ap_done), 0);
    chk("idle_after_done", longint'(ap_idle), 1);
    chk("out_count", longint'(nout), longint'(N_CH));
  endtask

  task automatic compare(input string tag, input int ed [N_CH], input bit en [N_CH]);
    for (int i = 0; i < N_CH; i++) begin
      chk($sformatf("%s_ch%0d_idx", tag, i), longint'(got_ch[i]), longint'(i));
      chk($sformatf("%s_ch%0d_data", tag, i), longint'(got_data[i]), longint'(ed[i]));
      chk($sformatf("%s_ch%0d_nospike", tag, i), longint'(got_ns[i]), longint'(en[i]));
      chk($sformatf("%s_ch%0d_last", tag, i), longint'(got_last[i]), longint'(i == N_CH - 1));
    end
  endtask

  initial begin
    spk_t rs [T_STEPS];
    int   md [N_CH];
    bit   mn [N_CH];
    bit   seen;

    ap_rst = 1'b1; ap_start = 1'b0; step_valid = 1'b0; out_ready = 1'b0; spike_in = '0;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", longint'(ap_idle), 1);
    chk("rst_done", longint'(ap_done), 0);
    chk("rst_step_ready", longint'(step_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_last", longint'(out_last), 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("idle_hold", longint'(ap_idle), 1);

    for (int v = 0; v < 3; v++) begin
      for (int s = 0; s < T_STEPS; s++) tbl[v].steps[s] = '0;
      for (int c = 0; c < N_CH; c++) begin
        tbl[v].exp_data[c] = 0;
        tbl[v].exp_ns[c]   = 1'b1;
      end
    end
    // ch0@0, ch1@5, ch7@15
    tbl[0].steps[0]  = 8'h01;
    tbl[0].steps[5]  = 8'h02;
    tbl[0].steps[15] = 8'h80;
    tbl[0].exp_data[0] = 16382; tbl[0].exp_ns[0] = 1'b0;
    tbl[0].exp_data[1] = 10921; tbl[0].exp_ns[1] = 1'b0;
    tbl[0].exp_data[7] = 0;     tbl[0].exp_ns[7] = 1'b0;
    // ch2@3, later spikes at 4 and 9 ignored
    tbl[1].steps[3] = 8'h04;
    tbl[1].steps[4] = 8'h04;
    tbl[1].steps[9] = 8'h04;
    tbl[1].exp_data[2] = 13106; tbl[1].exp_ns[2] = 1'b0;
    // every channel at step 0
    tbl[2].steps[0] = 8'hFF;
    for (int c = 0; c < N_CH; c++) begin
      tbl[2].exp_data[c] = 16382;
      tbl[2].exp_ns[c]   = 1'b0;
    end

    for (int v = 0; v < 3; v++) begin
      run_window(tbl[v].steps, 0, 0);
      compare($sformatf("vec%0d", v), tbl[v].exp_data, tbl[v].exp_ns);
      if (v == 0) chk("latency_continuous", longint'(first_valid), 17);
    end

    // step_valid toggling: only accepted steps advance the timestamp
    run_window(tbl[0].steps, 1, 0);
    compare("toggle", tbl[0].exp_data, tbl[0].exp_ns);
    chk("latency_toggle", longint'(first_valid), 32);

    // downstream stall on ch1
    run_window(tbl[0].steps, 0, 2);
    compare("stall", tbl[0].exp_data, tbl[0].exp_ns);
    chk("stall_cycles", longint'(stall_cycles), 5);

    // reset in the middle of a window
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    step_valid = 1'b1; spike_in = '1;
    repeat (7) @(negedge ap_clk);
    ap_rst = 1'b1; step_valid = 1'b0; spike_in = '0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("midrst_idle", longint'(ap_idle), 1);
    chk("midrst_step_ready", longint'(step_ready), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    seen = 0;
    repeat (25) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1;
    end
    chk("midrst_no_done", longint'(seen), 0);
    run_window(tbl[0].steps, 0, 0);
    compare("after_rst", tbl[0].exp_data, tbl[0].exp_ns);

    // randomized windows against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < T_STEPS; s++) rs[s] = N_CH'($urandom & $urandom & $urandom);
      model(rs, md, mn);
      run_window(rs, 2, 1);
      compare($sformatf("rnd%0d", r), md, mn);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
